uart_port: RTL
==============

Name: uart_port

Overview:
- Serial-side responder for the CPU's byte I/O handshake (tx_byte/transmit/is_transmitting, received/rx_byte).
- Transmitter serialises bytes issued by the CPU (OUTA).
- Receiver deserialises the line and presents bytes for the CPU (INA).
- Fixed 8N1 framing, LSB first, baud set by a clock divider; sits between cpu and the board's FTDI UART pins.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per bit (12 MHz / 115200); legal range 4..65535.
- CNT_W, 16, width of the bit-timing counters; must hold CLKS_PER_BIT-1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-low reset.
- tx_byte  in  8  byte to send; sampled only when transmit is accepted.
- transmit  in  1  one-cycle send request.
- is_transmitting  out  1  high while a frame is in flight.
- tx  out  1  serial output, idle high.
- rx  in  1  serial input, asynchronous to clk.
- rx_byte  out  8  last received byte; held until the next good frame.
- received  out  1  one-cycle pulse when rx_byte is updated.
- recv_error  out  1  one-cycle pulse on a framing error.
- is_receiving  out  1  high from a validated start bit to the end of the frame.

Behaviour:
- Reset (rst low, any time, asynchronous): tx=1, is_transmitting=0, rx_byte=0, received=0, recv_error=0, is_receiving=0; both FSMs go to IDLE and counters clear.
- Reset mid-frame aborts the frame; tx returns high immediately.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: transmit=1 at edge N latches tx_byte into the shift register. From N+1: is_transmitting=1 and tx=0 (START).
  - Each state lasts exactly CLKS_PER_BIT cycles.
  - DATA shifts out bits 0..7, LSB first. STOP drives tx=1.
  - After STOP the FSM returns to IDLE. is_transmitting falls exactly 10*CLKS_PER_BIT cycles after it rose.
  - Back-to-back: transmit in the first IDLE cycle starts the next START with no extra idle bit.
  - transmit while is_transmitting=1 is ignored. The byte is dropped and there is no error indication; the CPU must poll.
  - Changing tx_byte after acceptance does not affect the frame in flight.
- RX input conditioning: rx passes through a 2-flop synchroniser (reset value 1) before any use. This adds 2 cycles of latency, which is accounted for in the sample timing.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synchronised 1->0 transition enters START and loads the counter for half a bit.
  - START: at mid-bit, if the line is still 0, set is_receiving=1 and go to DATA. Otherwise treat it as a glitch and return to IDLE with no pulse.
  - DATA: sample at the centre of each bit (every CLKS_PER_BIT cycles), shifting LSB first.
  - STOP: sample at the centre of the stop bit.
    - Sample 1: rx_byte is updated and received=1 for exactly one cycle, in the same cycle as the update.
    - Sample 0: rx_byte is unchanged and recv_error=1 for one cycle.
    - In either case is_receiving=0 and the FSM returns to IDLE.
  - After a framing error, the FSM waits for the line to be high before arming for the next start edge, so a break condition yields one error, not repeated errors.
- The TX and RX paths are fully independent. Simultaneous transmit and receive is required, and the TX/RX loopback must work.
- Counters are unsigned CNT_W bits, count down to 0, and never wrap within a bit.

Decomposition:
- Shared package/header `uart_defs`: 8N1 constants (DATA_BITS=8, FRAME_BITS=10) and FSM state localparams for TX and RX.
- One natural sub-module: uart_bit_timer (load value, enable, done pulse). Instantiate it once for TX and once for RX.
- Synchroniser flops stay inline.

Test Plan (all with CLKS_PER_BIT=4):
- TX 0xA5: transmit pulse -> tx low for 4 cycles, then 1,0,1,0,0,1,0,1 at 4 cycles each, stop high; is_transmitting high for 40 cycles.
- TX busy drop: send 0x55, then transmit 0xFF 10 cycles later -> only the 0x55 frame appears; is_transmitting unchanged.
- RX 0x3C driven at exactly 4 clk/bit -> one received pulse; rx_byte=0x3C; recv_error stays 0.
- RX framing error: frame with stop=0, data 0x81 -> recv_error pulse; rx_byte keeps its previous value; no received pulse.
- RX glitch: rx low for 1 cycle -> no is_receiving, no pulses.
- Loopback tx->rx sending 0x00, 0xFF, 0x12 back-to-back -> three received pulses with matching bytes; assert rst low mid-frame -> tx=1 and all outputs at reset values within the same cycle.

Source files
------------

// File: rtl/uart_defs.sv
// Shared 8N1 framing constants and FSM state encodings for the UART port.
package uart_defs;

    localparam int DATA_BITS  = 8;
    localparam int FRAME_BITS = 10;

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2,
        TX_STOP  = 2'd3
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/uart_bit_timer.sv
// Down-counting bit timer: load sets the count, done is high while enabled at zero.
module uart_bit_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             done
);

    logic [CNT_W-1:0] cnt_reg;

    // Holds at zero instead of wrapping; the owner reloads on done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (en && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign done = en && (cnt_reg == '0);

endmodule

// File: rtl/uart_port.sv
// 8N1 UART with independent transmitter and receiver sharing one clock divider setting.
module uart_port
    import uart_defs::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_byte,
    input  logic       transmit,
    output logic       is_transmitting,
    output logic       tx,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       received,
    output logic       recv_error,
    output logic       is_receiving
);

    localparam logic [CNT_W-1:0] FULL_LOAD = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [2:0]       LAST_BIT  = 3'(DATA_BITS - 1);

    // ---------------- transmitter ----------------
    tx_state_t  tx_state_reg, tx_state_next;
    logic [7:0] tx_shift_reg, tx_shift_next;
    logic [2:0] tx_bit_reg, tx_bit_next;
    logic       tx_reg, tx_next;
    logic       tx_busy_reg, tx_busy_next;
    logic       tx_accept, tx_tick;

    always_comb begin
        tx_state_next = tx_state_reg;
        tx_shift_next = tx_shift_reg;
        tx_bit_next   = tx_bit_reg;
        tx_accept     = 1'b0;
        case (tx_state_reg)
            TX_IDLE: begin
                if (transmit) begin
                    tx_accept     = 1'b1;
                    tx_shift_next = tx_byte;
                    tx_bit_next   = '0;
                    tx_state_next = TX_START;
                end
            end
            TX_START: if (tx_tick) tx_state_next = TX_DATA;
            TX_DATA: begin
                if (tx_tick) begin
                    tx_shift_next = {1'b0, tx_shift_reg[7:1]};
                    tx_bit_next   = tx_bit_reg + 1'b1;
                    if (tx_bit_reg == LAST_BIT) tx_state_next = TX_STOP;
                end
            end
            default: if (tx_tick) tx_state_next = TX_IDLE;
        endcase
        // Line level is decoded from the next state so tx leaves a flop.
        tx_next = 1'b1;
        if (tx_state_next == TX_START)     tx_next = 1'b0;
        else if (tx_state_next == TX_DATA) tx_next = tx_shift_next[0];
        tx_busy_next = (tx_state_next != TX_IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tx_state_reg <= TX_IDLE;
            tx_shift_reg <= '0;
            tx_bit_reg   <= '0;
            tx_reg       <= 1'b1;
            tx_busy_reg  <= 1'b0;
        end else begin
            tx_state_reg <= tx_state_next;
            tx_shift_reg <= tx_shift_next;
            tx_bit_reg   <= tx_bit_next;
            tx_reg       <= tx_next;
            tx_busy_reg  <= tx_busy_next;
        end
    end

    uart_bit_timer #(.CNT_W(CNT_W)) u_tx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tx_accept || tx_tick),
        .load_val (FULL_LOAD),
        .en       (tx_state_reg != TX_IDLE),
        .done     (tx_tick)
    );

    assign tx              = tx_reg;
    assign is_transmitting = tx_busy_reg;

    // ---------------- receiver ----------------
    logic       rx_meta_reg, rx_sync_reg, rx_prev_reg;
    rx_state_t  rx_state_reg, rx_state_next;
    logic [7:0] rx_shift_reg, rx_shift_next;
    logic [2:0] rx_bit_reg, rx_bit_next;
    logic [7:0] rx_byte_reg, rx_byte_next;
    logic       received_reg, received_next;
    logic       recv_error_reg, recv_error_next;
    logic       is_receiving_reg, is_receiving_next;
    logic       rx_load, rx_tick;
    logic [CNT_W-1:0] rx_load_val;

    always_comb begin
        rx_state_next   = rx_state_reg;
        rx_shift_next   = rx_shift_reg;
        rx_bit_next     = rx_bit_reg;
        rx_byte_next    = rx_byte_reg;
        received_next   = 1'b0;
        recv_error_next = 1'b0;
        rx_load         = 1'b0;
        case (rx_state_reg)
            RX_IDLE: begin
                // Edge-armed: a line held low after a framing error cannot retrigger.
                if (rx_prev_reg && !rx_sync_reg) begin
                    rx_load       = 1'b1;
                    rx_state_next = RX_START;
                end
            end
            RX_START: begin
                if (rx_tick) begin
                    rx_load       = 1'b1;
                    rx_bit_next   = '0;
                    rx_state_next = rx_sync_reg ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_tick) begin
                    rx_load       = 1'b1;
                    rx_shift_next = {rx_sync_reg, rx_shift_reg[7:1]};
                    rx_bit_next   = rx_bit_reg + 1'b1;
                    if (rx_bit_reg == LAST_BIT) rx_state_next = RX_STOP;
                end
            end
            default: begin
                if (rx_tick) begin
                    rx_state_next = RX_IDLE;
                    if (rx_sync_reg) begin
                        rx_byte_next  = rx_shift_reg;
                        received_next = 1'b1;
                    end else begin
                        recv_error_next = 1'b1;
                    end
                end
            end
        endcase
        is_receiving_next = (rx_state_next == RX_DATA) || (rx_state_next == RX_STOP);
        rx_load_val       = (rx_state_reg == RX_IDLE) ? HALF_LOAD : FULL_LOAD;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_reg      <= 1'b1;
            rx_sync_reg      <= 1'b1;
            rx_prev_reg      <= 1'b1;
            rx_state_reg     <= RX_IDLE;
            rx_shift_reg     <= '0;
            rx_bit_reg       <= '0;
            rx_byte_reg      <= '0;
            received_reg     <= 1'b0;
            recv_error_reg   <= 1'b0;
            is_receiving_reg <= 1'b0;
        end else begin
            rx_meta_reg      <= rx;
            rx_sync_reg      <= rx_meta_reg;
            rx_prev_reg      <= rx_sync_reg;
            rx_state_reg     <= rx_state_next;
            rx_shift_reg     <= rx_shift_next;
            rx_bit_reg       <= rx_bit_next;
            rx_byte_reg      <= rx_byte_next;
            received_reg     <= received_next;
            recv_error_reg   <= recv_error_next;
            is_receiving_reg <= is_receiving_next;
        end
    end

    uart_bit_timer #(.CNT_W(CNT_W)) u_rx_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (rx_load),
        .load_val (rx_load_val),
        .en       (rx_state_reg != RX_IDLE),
        .done     (rx_tick)
    );

    assign rx_byte      = rx_byte_reg;
    assign received     = received_reg;
    assign recv_error   = recv_error_reg;
    assign is_receiving = is_receiving_reg;

endmodule
